// File: rtl/perf_counter_bank.sv
// perf_counter_bank: a bank of N_CNT event counters, each CNT_W bits wide,
// read and written through an XLEN-wide CSR-style port. Each counter has a
// sticky overflow flag. When a counter is wider than the port, a low-half
// read also snapshots the high half, so that the following high-half read
// returns a coherent value.
module perf_counter_bank #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64,
  parameter int N_CNT = 5,
  parameter int INC   = 1,
  localparam int IDX_W = (N_CNT > 1) ? $clog2(N_CNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CNT-1:0] evt_i,
  input  logic [N_CNT-1:0] inhibit_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_sel_i,
  input  logic             rd_hi_i,
  output logic [XLEN-1:0]  rd_data_o,
  output logic             rd_valid_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_sel_i,
  input  logic             wr_hi_i,
  input  logic [XLEN-1:0]  wr_data_i,
  output logic [N_CNT-1:0] ovf_o,
  input  logic [N_CNT-1:0] ovf_clr_i
);

  // A high half exists only when the counter is wider than the port.
  localparam logic             HAS_HI  = (CNT_W > XLEN);
  localparam logic [CNT_W-1:0] LO_MASK = CNT_W'({XLEN{1'b1}});
  localparam logic [CNT_W:0]   INC_EXT = (CNT_W + 1)'(INC);

  logic [CNT_W-1:0] cnt      [N_CNT];
  logic [CNT_W-1:0] cnt_nxt  [N_CNT];
  logic [N_CNT-1:0] ovf_set;
  logic [N_CNT-1:0] ovf_flags;

  logic             wr_ok;
  logic             wr_hi_eff;
  logic [CNT_W-1:0] wr_mask;
  logic [CNT_W-1:0] wr_val;

  logic             rd_ok;
  logic             rd_hi_eff;
  logic [CNT_W-1:0] rd_word;
  logic [XLEN-1:0]  rd_lo;
  logic [XLEN-1:0]  rd_hi_live;
  logic [XLEN-1:0]  rd_data;
  logic             rd_valid;

  logic [XLEN-1:0]  shadow_hi;
  logic [XLEN-1:0]  shadow_hi_nxt;
  logic             shadow_vld;
  logic             shadow_vld_nxt;
  logic [IDX_W-1:0] shadow_tag;
  logic [IDX_W-1:0] shadow_tag_nxt;
  logic             shadow_hit;

  // Write decode: merge the XLEN-wide write data into the selected half.
  always_comb begin
    wr_ok     = wr_en_i && (int'(wr_sel_i) < N_CNT);
    wr_hi_eff = wr_hi_i & HAS_HI;
    if (wr_hi_eff) begin
      // Shifting past CNT_W drops any write bits above the counter width.
      wr_mask = ~LO_MASK;
      wr_val  = CNT_W'(wr_data_i) << XLEN;
    end else begin
      wr_mask = LO_MASK;
      wr_val  = CNT_W'(wr_data_i);
    end
  end

  // Counter next state: a write beats an increment, and a write to one
  // counter leaves every other counter free to count.
  always_comb begin
    for (int k = 0; k < N_CNT; k++) begin
      ovf_set[k] = 1'b0;
      cnt_nxt[k] = cnt[k];
      if (wr_ok && (int'(wr_sel_i) == k)) begin
        cnt_nxt[k] = (cnt[k] & ~wr_mask) | (wr_val & wr_mask);
      end else if (evt_i[k] && !inhibit_i[k]) begin
        {ovf_set[k], cnt_nxt[k]} = {1'b0, cnt[k]} + INC_EXT;
      end else begin
        cnt_nxt[k] = cnt[k];
      end
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CNT; k++) begin
        cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CNT; k++) begin
        cnt[k] <= cnt_nxt[k];
      end
    end
  end

  // Sticky overflow flags; a new wrap wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flags <= '0;
    end else begin
      ovf_flags <= ovf_set | (ovf_flags & ~ovf_clr_i);
    end
  end

  // Read mux on the pre-edge counter values; unknown indices read as zero.
  always_comb begin
    rd_ok     = (int'(rd_sel_i) < N_CNT);
    rd_hi_eff = rd_hi_i & HAS_HI;
    if (rd_ok) begin
      rd_word = cnt[rd_sel_i];
    end else begin
      rd_word = '0;
    end
    rd_lo      = rd_word[XLEN-1:0];
    rd_hi_live = XLEN'(rd_word >> XLEN);
    shadow_hit = shadow_vld && (shadow_tag == rd_sel_i);
  end

  // Shadow bookkeeping: a low read captures the high half, the matching
  // high read consumes it, and any write to the tagged counter kills it.
  always_comb begin
    shadow_hi_nxt  = shadow_hi;
    shadow_vld_nxt = shadow_vld;
    shadow_tag_nxt = shadow_tag;
    if (rd_en_i && HAS_HI) begin
      if (!rd_hi_eff && rd_ok) begin
        shadow_hi_nxt  = rd_hi_live;
        shadow_vld_nxt = 1'b1;
        shadow_tag_nxt = rd_sel_i;
      end else if (rd_hi_eff && shadow_hit) begin
        shadow_vld_nxt = 1'b0;
      end else begin
        shadow_vld_nxt = shadow_vld;
      end
    end else begin
      shadow_vld_nxt = shadow_vld;
    end
    if (wr_ok && (wr_sel_i == shadow_tag_nxt)) begin
      shadow_vld_nxt = 1'b0;
    end else begin
      shadow_tag_nxt = shadow_tag_nxt;
    end
  end

  // Shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_hi  <= '0;
      shadow_vld <= 1'b0;
      shadow_tag <= '0;
    end else begin
      shadow_hi  <= shadow_hi_nxt;
      shadow_vld <= shadow_vld_nxt;
      shadow_tag <= shadow_tag_nxt;
    end
  end

  // Registered read response: valid one cycle after the request, data held
  // between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en_i;
      if (rd_en_i) begin
        if (rd_hi_eff) begin
          rd_data <= shadow_hit ? shadow_hi : rd_hi_live;
        end else begin
          rd_data <= rd_lo;
        end
      end else begin
        rd_data <= rd_data;
      end
    end
  end

  assign rd_data_o  = rd_data;
  assign rd_valid_o = rd_valid;
  assign ovf_o      = ovf_flags;

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter XLEN, default 32, CSR data width; the only legal values are 32 and 64.
REQ-002 Parameter CNT_W, default 64, counter width; CNT_W SHALL be greater than or equal to XLEN and at most 2*XLEN.
REQ-003 Parameter N_CNT, default 5, number of counters; the legal range is 1..16.
REQ-004 Parameter INC, default 1, increment per qualified event; the legal range is 1..255.
REQ-005 Derived IDX_W = max(1, ceil(log2(N_CNT))).
REQ-006 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 evt_i  in  N_CNT  per-counter event strobe.
REQ-009 inhibit_i  in  N_CNT  per-counter count inhibit.
REQ-010 rd_en_i  in  1  read request.
REQ-011 rd_sel_i  in  IDX_W  counter index for a read.
REQ-012 rd_hi_i  in  1  half select for a read: 0 = bits [XLEN-1:0], 1 = bits [CNT_W-1:XLEN].
REQ-013 rd_data_o  out  XLEN  read data.
REQ-014 rd_valid_o  out  1  read data valid.
REQ-015 wr_en_i  in  1  write request.
REQ-016 wr_sel_i  in  IDX_W  counter index for a write.
REQ-017 wr_hi_i  in  1  half select for a write.
REQ-018 wr_data_i  in  XLEN  write data.
REQ-019 ovf_o  out  N_CNT  sticky overflow flags.
REQ-020 ovf_clr_i  in  N_CNT  per-counter overflow clear.

Function
REQ-021 Counter k SHALL add INC, modulo 2^CNT_W, on each clock where evt_i[k]=1 and inhibit_i[k]=0; otherwise it SHALL hold.
REQ-022 Overflow: when cnt[k]+INC >= 2^CNT_W on a counting cycle, the counter SHALL wrap to the low CNT_W bits and ovf_o[k] SHALL be set on the same edge.
REQ-023 ovf_o[k] SHALL stay set until ovf_clr_i[k]=1; if set and clear occur in the same cycle, set SHALL win.
REQ-024 Write: wr_en_i=1 SHALL load wr_data_i into the selected half of cnt[wr_sel_i].
  - the other half is unchanged;
  - in the high half, bits above CNT_W are discarded.
REQ-025 A write SHALL take priority over an increment of the same counter in the same cycle; that event is lost and the overflow flag is not set.
REQ-026 A write SHALL NOT affect any other counter's increment.
REQ-027 Read latency SHALL be 1 cycle: rd_valid_o=1 in the cycle after rd_en_i=1 and 0 otherwise.
REQ-028 rd_data_o SHALL hold its last value until the next read completes.
REQ-029 Read data SHALL be the counter value before the edge on which rd_en_i is sampled: no increment or write from that same cycle is visible.
REQ-030 Coherent 64-bit read, when XLEN < CNT_W:
  - a low-half read of counter s SHALL also capture bits [CNT_W-1:XLEN] of the same pre-edge value into a shadow register, and mark the shadow valid with tag s;
  - a high-half read whose rd_sel_i equals the tag while the shadow is valid SHALL return the shadow, zero-extended, and then invalidate the shadow;
  - any other high-half read SHALL return the live high bits.
REQ-031 Any write to the tagged counter SHALL invalidate the shadow.
REQ-032 When XLEN = CNT_W, rd_hi_i and wr_hi_i SHALL be ignored, full-width access SHALL apply, and there SHALL be no shadow.
REQ-033 rd_sel_i >= N_CNT SHALL return 0 with rd_valid_o still asserted; wr_sel_i >= N_CNT SHALL be ignored.
REQ-034 Simultaneous read and write of the same counter and half SHALL return the pre-write value, per REQ-029.
REQ-035 Inhibit SHALL gate only counting; reads, writes and overflow clear SHALL operate while inhibited.

Reset
REQ-036 rst=1 SHALL asynchronously force:
  - all counters to 0;
  - ovf_o to 0;
  - rd_data_o to 0;
  - rd_valid_o to 0;
  - the shadow to invalid.
REQ-037 Reset asserted mid-operation SHALL abort any pending read, so no rd_valid_o pulse is produced.
REQ-038 After release, the first counting edge SHALL be the first rising clk with rst=0.

Verification
REQ-039 Reset release, evt_i[0]=1 for 10 cycles, INC=1 -> a low read of counter 0 returns 10 with rd_valid_o high one cycle later.
REQ-040 Write 0xFFFFFFFF to the low half and 0xFFFFFFFF to the high half of counter 2, then one event -> cnt[2]=0 and ovf_o[2]=1.
  - ovf_clr_i[2] pulse together with another wrap -> ovf_o[2] stays 1;
  - a lone ovf_clr_i[2] pulse -> ovf_o[2]=0.
REQ-041 Coherent read: cnt[1]=0x00000000_FFFFFFFF with a continuous event stream.
  - low read returns 0xFFFFFFFF;
  - the next-cycle high read returns 0x00000000 although the live value is now 0x00000001_00000000 or higher.
REQ-042 Same cycle: wr_en_i to the low half of counter 3 with 0x20, evt_i[3]=1, and rd_en_i on counter 3 low half, with cnt[3]=5.
  - rd_data_o=5;
  - cnt[3]=0x20, with no increment.
REQ-043 inhibit_i[4]=1 with evt_i[4]=1 for 8 cycles -> cnt[4] is unchanged.
  - rd_sel_i=7 with N_CNT=5 -> rd_data_o=0 and rd_valid_o=1.
REQ-044 rst pulse one cycle after rd_en_i, with counters non-zero -> rd_valid_o never asserts, and all counters and ovf_o read 0 afterwards.
